// File: rtl/demux_1to2_stream.sv
// Registered 1-to-2 stream demultiplexer: routes each accepted input word
// to branch 0 or branch 1 (per-word sel) through a one-entry output slot
// per branch, and counts words delivered on each branch.
module demux_1to2_stream #(
  parameter int unsigned W     = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     A,
  input  logic             sel,
  input  logic             a_valid,
  output logic             a_ready,
  output logic [W-1:0]     Y0,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [W-1:0]     Y1,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [W-1:0]     y0_q, y0_d, y1_q, y1_d;
  logic             y0_valid_q, y0_valid_d, y1_valid_q, y1_valid_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic free0, free1, acc0, acc1, dlv0, dlv1;

  // Slot availability, input handshake and per-branch accept/deliver events
  always_comb begin
    free0   = ~y0_valid_q | y0_ready;
    free1   = ~y1_valid_q | y1_ready;
    // Only the selected slot gates the input; a stalled branch blocks both.
    a_ready = sel ? free1 : free0;
    acc0    = a_valid & a_ready & ~sel;
    acc1    = a_valid & a_ready & sel;
    dlv0    = y0_valid_q & y0_ready;
    dlv1    = y1_valid_q & y1_ready;
  end

  // Next-state for both slots and delivery counters
  always_comb begin
    y0_d       = y0_q;
    y1_d       = y1_q;
    y0_valid_d = y0_valid_q;
    y1_valid_d = y1_valid_q;
    cnt0_d     = cnt0_q + CNT_W'(dlv0);
    cnt1_d     = cnt1_q + CNT_W'(dlv1);
    // A refill in the delivery cycle keeps the slot full with the new word.
    if (acc0) begin
      y0_d       = A;
      y0_valid_d = 1'b1;
    end else if (dlv0) begin
      y0_valid_d = 1'b0;
    end
    if (acc1) begin
      y1_d       = A;
      y1_valid_d = 1'b1;
    end else if (dlv1) begin
      y1_valid_d = 1'b0;
    end
  end

  // State registers; reset discards pending words and clears counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y0_q       <= '0;
      y1_q       <= '0;
      y0_valid_q <= 1'b0;
      y1_valid_q <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      y0_valid_q <= y0_valid_d;
      y1_valid_q <= y1_valid_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  // Output drive from the registered state
  always_comb begin
    Y0       = y0_q;
    Y1       = y1_q;
    y0_valid = y0_valid_q;
    y1_valid = y1_valid_q;
    cnt0     = cnt0_q;
    cnt1     = cnt1_q;
  end

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Directed-vector bench for demux_1to2_stream (W=2, CNT_W=8).
module tb_demux_1to2_stream;

  localparam int unsigned W     = 2;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     A;
  logic             sel, a_valid, a_ready;
  logic [W-1:0]     Y0, Y1;
  logic             y0_valid, y0_ready, y1_valid, y1_ready;
  logic [CNT_W-1:0] cnt0, cnt1;

  int n_total = 0;
  int n_pass  = 0;

  demux_1to2_stream #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .A(A), .sel(sel), .a_valid(a_valid), .a_ready(a_ready),
    .Y0(Y0), .y0_valid(y0_valid), .y0_ready(y0_ready),
    .Y1(Y1), .y1_valid(y1_valid), .y1_ready(y1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic         sel, av, r0, r1;
    logic         e_ready;
    logic [W-1:0] e_y0;
    logic         e_v0;
    logic [W-1:0] e_y1;
    logic         e_v1;
    int           e_c0, e_c1;
  } vec_t;

  function automatic vec_t mk(logic [W-1:0] a, logic s, logic av, logic r0, logic r1,
                              logic er, logic [W-1:0] y0, logic v0,
                              logic [W-1:0] y1, logic v1, int c0, int c1);
    vec_t v;
    v.a = a; v.sel = s; v.av = av; v.r0 = r0; v.r1 = r1; v.e_ready = er;
    v.e_y0 = y0; v.e_v0 = v0; v.e_y1 = y1; v.e_v1 = v1; v.e_c0 = c0; v.e_c1 = c1;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic s, input logic av,
                       input logic r0, input logic r1);
    A = a; sel = s; a_valid = av; y0_ready = r0; y1_ready = r1;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] y0, input logic v0,
                         input logic [W-1:0] y1, input logic v1, input int c0, input int c1);
    chk({tag, ".Y0"}, int'(Y0), int'(y0));
    chk({tag, ".y0_valid"}, int'(y0_valid), int'(v0));
    chk({tag, ".Y1"}, int'(Y1), int'(y1));
    chk({tag, ".y1_valid"}, int'(y1_valid), int'(v1));
    chk({tag, ".cnt0"}, int'(cnt0), c0);
    chk({tag, ".cnt1"}, int'(cnt1), c1);
  endtask

  vec_t vecs[13];

  initial begin
    // routing, backpressure, head-of-line, simultaneous delivery
    //              A    sel av r0 r1  rdy Y0  v0  Y1  v1  c0 c1
    vecs[0]  = mk(2'b10, 0, 1, 1, 1,  1, 2'b10, 1, 2'b00, 0, 0, 0);
    vecs[1]  = mk(2'b01, 1, 1, 1, 1,  1, 2'b10, 0, 2'b01, 1, 1, 0);
    vecs[2]  = mk(2'b00, 0, 0, 1, 1,  1, 2'b10, 0, 2'b01, 0, 1, 1);
    vecs[3]  = mk(2'b11, 1, 1, 1, 0,  1, 2'b10, 0, 2'b11, 1, 1, 1);
    vecs[4]  = mk(2'b00, 1, 1, 1, 0,  0, 2'b10, 0, 2'b11, 1, 1, 1);
    vecs[5]  = mk(2'b00, 1, 1, 1, 1,  1, 2'b10, 0, 2'b00, 1, 1, 2);
    vecs[6]  = mk(2'b00, 1, 0, 1, 0,  0, 2'b10, 0, 2'b00, 1, 1, 2);
    vecs[7]  = mk(2'b01, 0, 1, 0, 0,  1, 2'b01, 1, 2'b00, 1, 1, 2);
    vecs[8]  = mk(2'b00, 0, 0, 0, 1,  0, 2'b01, 1, 2'b00, 0, 1, 3);
    vecs[9]  = mk(2'b10, 1, 1, 0, 0,  1, 2'b01, 1, 2'b10, 1, 1, 3);
    vecs[10] = mk(2'b11, 0, 1, 0, 0,  0, 2'b01, 1, 2'b10, 1, 1, 3);
    vecs[11] = mk(2'b11, 0, 1, 1, 0,  1, 2'b11, 1, 2'b10, 1, 2, 3);
    vecs[12] = mk(2'b00, 0, 0, 1, 1,  1, 2'b11, 0, 2'b10, 0, 3, 4);

    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    chk_out("reset", 2'b00, 0, 2'b00, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("reset.a_ready", int'(a_ready), 1);
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].a, vecs[i].sel, vecs[i].av, vecs[i].r0, vecs[i].r1);
      #1;
      chk($sformatf("v%0d.a_ready", i), int'(a_ready), int'(vecs[i].e_ready));
      tick();
      chk_out($sformatf("v%0d", i), vecs[i].e_y0, vecs[i].e_v0, vecs[i].e_y1,
              vecs[i].e_v1, vecs[i].e_c0, vecs[i].e_c1);
    end

    // fill both slots, then assert reset mid-cycle
    drive(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("prefill", 2'b01, 1, 2'b10, 1, 3, 4);
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("midrst", 2'b00, 0, 2'b00, 0, 0, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst.a_ready", int'(a_ready), 1);
    tick();

    // 256-word stream on branch 0: one accept per cycle, cnt0 wraps
    for (int k = 0; k < 256; k++) begin
      drive(W'(k), 1'b0, 1'b1, 1'b1, 1'b1);
      #1;
      chk($sformatf("stream%0d.a_ready", k), int'(a_ready), 1);
      tick();
      chk($sformatf("stream%0d.Y0", k), int'(Y0), k % 4);
      chk($sformatf("stream%0d.y0_valid", k), int'(y0_valid), 1);
      chk($sformatf("stream%0d.cnt0", k), int'(cnt0), k);
    end
    drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("wrap", 2'b11, 0, 2'b00, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
